ntt_result_drain: RTL and testbench

- Read-side consumer of the NTT core's result FIFO. The core pushes packed 32-bit words {coef_a[15:0], coef_b[15:0]} during its output phase.
- Pops exactly WORDS words, splits each word into two coefficients (upper half first), and reduces each coefficient to canonical range [0,Q).
- Presents coefficients on a valid/ready stream with a running index, toward the host or bus bridge.
- Runs entirely in the FIFO read-clock domain.

---
 rtl/ntt_result_drain_if.sv | 37 +++
 rtl/ntt_result_drain.sv | 152 +++++++++++++++
 tb/tb_ntt_result_drain.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_result_drain_if.sv
// ntt_result_drain_if
//   Groups the two streaming sides of the NTT result drain.
//   FIFO read port : rd_req (drain -> FIFO), rd_dat, rd_empty (FIFO -> drain).
//   Coef stream    : coef_valid, coef_data, coef_idx (drain -> sink),
//                    coef_ready (sink -> drain).
//   master = the drain block, slave = the FIFO/sink side (testbench or bridge).
interface ntt_result_drain_if #(
    parameter int IDXW = 8
);
    logic            rd_req;
    logic [31:0]     rd_dat;
    logic            rd_empty;
    logic            coef_valid;
    logic            coef_ready;
    logic [15:0]     coef_data;
    logic [IDXW-1:0] coef_idx;

    modport master (
        output rd_req,
        input  rd_dat,
        input  rd_empty,
        output coef_valid,
        input  coef_ready,
        output coef_data,
        output coef_idx
    );

    modport slave (
        input  rd_req,
        output rd_dat,
        output rd_empty,
        input  coef_valid,
        output coef_ready,
        input  coef_data,
        input  coef_idx
    );
endinterface

// File: rtl/ntt_result_drain.sv
// ntt_result_drain
//   Drains one polynomial (WORDS packed words) from the NTT result FIFO,
//   splits each word into two signed 16-bit coefficients (upper half first),
//   reduces each to [0,Q) and emits them on a valid/ready stream with index.
//   Ports:
//     clk, rst_n : FIFO read clock, asynchronous active-low reset
//     start      : one-cycle pulse, begins a drain when idle
//     bus        : FIFO read port + coefficient stream (master modport)
//     busy       : drain in progress
//     done       : one-cycle pulse after the last coefficient is accepted
//     range_err  : sticky, an input coefficient was outside [-Q,2Q)
module ntt_result_drain #(
    parameter int WORDS = 128,
    parameter int Q     = 3329,
    parameter int IDXW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    ntt_result_drain_if.master      bus,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err
);
    localparam int                     WCW      = $clog2(WORDS + 1);
    localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(2 * WORDS - 1);
    localparam logic signed [17:0]     QP       = 18'(Q);
    localparam logic signed [17:0]     QN       = 18'(-Q);
    localparam logic signed [17:0]     Q2       = 18'(2 * Q);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [WCW-1:0]  words_req;
    logic            rd_pend;        // read issued last cycle, data on rd_dat now
    logic [31:0]     buf_mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      buf_cnt;
    logic [1:0]      occ;
    logic            half;           // 0: next coef is upper half, 1: lower half
    logic            coef_valid_q;
    logic [15:0]     coef_data_q;
    logic [IDXW-1:0] coef_idx_q;
    logic            hs, last_hs, load, push, pop;
    logic [15:0]     raw;
    logic [16:0]     canon_res;

    // Returns {out_of_range, value}; out-of-range inputs pass through unchanged.
    function automatic logic [16:0] canon(input logic [15:0] c);
        logic signed [17:0] v;
        logic signed [17:0] r;
        v = {{2{c[15]}}, c};
        if (v < QN || v >= Q2) begin
            return {1'b1, c};
        end else if (v < 18'sd0) begin
            r = v + QP;
        end else if (v >= QP) begin
            r = v - QP;
        end else begin
            r = v;
        end
        return {1'b0, r[15:0]};
    endfunction

    assign hs        = coef_valid_q & bus.coef_ready;
    assign last_hs   = hs && (coef_idx_q == LAST_IDX);
    assign occ       = buf_cnt + {1'b0, rd_pend};
    assign push      = rd_pend;
    // Output register refills when empty or being accepted this cycle.
    assign load      = (state == S_RUN) && (buf_cnt != 2'd0) && (!coef_valid_q || bus.coef_ready);
    assign pop       = load && half;
    assign raw       = half ? buf_mem[rd_ptr][15:0] : buf_mem[rd_ptr][31:16];
    assign canon_res = canon(raw);

    // Occupancy counts in-flight reads so a late rd_dat can never overflow the buffer;
    // it depends only on registered state, keeping coef_ready off this path.
    assign bus.rd_req = (state == S_RUN) && !bus.rd_empty &&
                        (words_req < WCW'(WORDS)) && (occ < 2'd2);

    assign bus.coef_valid = coef_valid_q;
    assign bus.coef_data  = coef_data_q;
    assign bus.coef_idx   = coef_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_hs) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the word buffer holds data only; validity lives in buf_cnt, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr] <= bus.rd_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            words_req    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            buf_cnt      <= 2'd0;
            half         <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_data_q  <= 16'd0;
            coef_idx_q   <= '0;
            range_err    <= 1'b0;
        end else begin
            rd_pend <= bus.rd_req;

            if (state == S_IDLE && start) begin
                words_req <= '0;
                range_err <= 1'b0;
            end else if (bus.rd_req) begin
                words_req <= words_req + 1'b1;
            end

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);

            if (load) begin
                coef_valid_q <= 1'b1;
                coef_data_q  <= canon_res[15:0];
                half         <= ~half;
                if (canon_res[16]) range_err <= 1'b1;
            end else if (hs) begin
                coef_valid_q <= 1'b0;
            end

            // Index names the coefficient in the register; wraps to 0 after the last one.
            if (hs) coef_idx_q <= last_hs ? '0 : coef_idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_ntt_result_drain.sv
// tb_ntt_result_drain
//   Self-checking bench: a FIFO model feeds packed words, a scoreboard of
//   expected {data, idx} pairs is filled when words are queued and compared
//   on every stream handshake. Monitors watch rd_req-while-empty, stall
//   stability and the two-word occupancy bound.
module tb_ntt_result_drain;
    localparam int WORDS = 128;
    localparam int Q     = 3329;
    localparam int IDXW  = 8;
    localparam int NCOEF = 2 * WORDS;

    typedef struct packed {
        logic [15:0]     data;
        logic [IDXW-1:0] idx;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, range_err;

    ntt_result_drain_if #(.IDXW(IDXW)) bus();

    ntt_result_drain #(.WORDS(WORDS), .Q(Q), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];
    int feed_gap = 0, gap_cnt = 0;
    int issued = 0, hs_count = 0, odd_acc = 0, cyc = 0;
    int first_hs_cyc = 0, last_hs_cyc = 0, last_hs_idx = 0;
    int viol_empty = 0, viol_stall = 0, viol_held = 0;
    bit prev_stall = 1'b0;
    logic [15:0]     prev_data;
    logic [IDXW-1:0] prev_idx;
    int n_tests = 0, n_fail = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: normal mode, data presented the cycle after the request edge.
    initial begin : fifo_model
        bit req;
        forever begin
            @(negedge clk);
            req = rst_n && bus.rd_req;
            @(posedge clk);
            #1;
            if (req && fifo_q.size() > 0) begin
                bus.rd_dat = fifo_q.pop_front();
                issued++;
            end
            if (feed_gap == 0) begin
                while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
            end else if (src_q.size() > 0) begin
                if (gap_cnt == 0) begin
                    fifo_q.push_back(src_q.pop_front());
                    gap_cnt = feed_gap;
                end else begin
                    gap_cnt--;
                end
            end
            bus.rd_empty = (fifo_q.size() == 0);
        end
    end

    // Stream monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int   held;
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (bus.rd_req && bus.rd_empty) viol_empty++;
            held = issued - odd_acc - ((bus.coef_valid && bus.coef_idx[0]) ? 1 : 0);
            if (held > 2) viol_held++;
            if (prev_stall && (!bus.coef_valid || bus.coef_data !== prev_data || bus.coef_idx !== prev_idx))
                viol_stall++;
            prev_stall = bus.coef_valid && !bus.coef_ready;
            prev_data  = bus.coef_data;
            prev_idx   = bus.coef_idx;
            if (bus.coef_valid && bus.coef_ready) begin
                hs_count++;
                if (hs_count == 1) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                last_hs_idx = int'(bus.coef_idx);
                if (bus.coef_idx[0]) odd_acc++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_coef", 32'(bus.coef_idx), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("coef_data", 32'(bus.coef_data), 32'(e.data));
                    check("coef_idx", 32'(bus.coef_idx), 32'(e.idx));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic reset_counters();
        issued = 0; hs_count = 0; odd_acc = 0;
        first_hs_cyc = 0; last_hs_cyc = 0; last_hs_idx = 0;
        viol_empty = 0; viol_stall = 0; viol_held = 0;
    endtask

    // Queue a polynomial: word 0 is w0, word k>0 is {2k, 2k+1}.
    task automatic load_poly(input logic [31:0] w0, input logic [15:0] ea,
                             input logic [15:0] eb, input int gap);
        logic [31:0] w;
        feed_gap = gap;
        gap_cnt  = 0;
        for (int k = 0; k < WORDS; k++) begin
            w = (k == 0) ? w0 : {16'(2 * k), 16'(2 * k + 1)};
            src_q.push_back(w);
            sb.push_back('{data: (k == 0) ? ea : 16'(2 * k),     idx: IDXW'(2 * k)});
            sb.push_back('{data: (k == 0) ? eb : 16'(2 * k + 1), idx: IDXW'(2 * k + 1)});
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that sampled start.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("range_err_cleared_by_start", 32'(range_err), 32'd0);
    endtask

    task automatic run_drain(input int bound, input int ready_mode,
                             input bit start_in_done, input bit start_while_busy);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < bound) begin
            bus.coef_ready = (ready_mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            start = start_while_busy && (n == 40);
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_within_bound", 32'(seen), 32'd1);
        if (seen) begin
            check("done_cycle_after_last_hs", 32'(cyc - last_hs_cyc), 32'd0);
            check("last_hs_idx", 32'(last_hs_idx), 32'(NCOEF - 1));
            check("handshake_count", 32'(hs_count), 32'(NCOEF));
            check("pop_count", 32'(issued), 32'(WORDS));
            check("scoreboard_empty", 32'(sb.size()), 32'd0);
            check("busy_in_done", 32'(busy), 32'd0);
            check("valid_after_last", 32'(bus.coef_valid), 32'd0);
            check("idx_after_last", 32'(bus.coef_idx), 32'd0);
            start = start_in_done;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("done_single_pulse", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
        end
        check("rd_req_while_empty", 32'(viol_empty), 32'd0);
        check("occupancy_over_2", 32'(viol_held), 32'd0);
        check("stall_not_stable", 32'(viol_stall), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_req"},     32'(bus.rd_req),     32'd0);
        check({tag, "_coef_valid"}, 32'(bus.coef_valid), 32'd0);
        check({tag, "_coef_data"},  32'(bus.coef_data),  32'd0);
        check({tag, "_coef_idx"},   32'(bus.coef_idx),   32'd0);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_done"},       32'(done),           32'd0);
        check({tag, "_range_err"},  32'(range_err),      32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        bit found;
        bus.rd_dat     = 32'd0;
        bus.rd_empty   = 1'b1;
        bus.coef_ready = 1'b0;

        vecs[0] = '{32'hFFFF_0D01, 16'd3328, 16'd0,    1'b0};
        vecs[1] = '{32'h1A01_F2FF, 16'd3328, 16'd0,    1'b0};
        vecs[2] = '{32'h0C00_FFFE, 16'd3072, 16'd3327, 1'b0};
        vecs[3] = '{32'hF300_1000, 16'd1,    16'd767,  1'b0};
        vecs[4] = '{32'h1A02_8000, 16'h1A02, 16'h8000, 1'b1};
        vecs[5] = '{32'h7FFF_1A00, 16'h7FFF, 16'd3327, 1'b1};
        vecs[6] = '{32'h0D00_F2FE, 16'd3328, 16'hF2FE, 1'b1};

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Baseline: data equals index, latency, no bubbles, start in DONE ignored.
        reset_counters();
        load_poly(32'h0000_0001, 16'd0, 16'd1, 0);
        wait_cycles(3);
        bus.coef_ready = 1'b1;
        pulse_start();
        check("rd_req_after_start", 32'(bus.rd_req), 32'd1);
        wait_cycles(2);
        check("valid_not_before_e3", 32'(bus.coef_valid), 32'd0);
        wait_cycles(1);
        check("valid_after_e3", 32'(bus.coef_valid), 32'd1);
        check("first_idx", 32'(bus.coef_idx), 32'd0);
        run_drain(600, 0, 1'b1, 1'b0);
        check("no_bubbles", 32'(last_hs_cyc - first_hs_cyc), 32'(NCOEF - 1));

        // Canonicalisation table: first word of each drain carries the vector.
        for (int i = 0; i < 7; i++) begin
            reset_counters();
            load_poly(vecs[i].word, vecs[i].exp_a, vecs[i].exp_b, 0);
            wait_cycles(3);
            pulse_start();
            run_drain(600, 0, 1'b0, 1'b0);
            check($sformatf("range_err_vec%0d", i), 32'(range_err), 32'(vecs[i].exp_err));
        end

        // Backpressure 1,0,0,1 with a full FIFO, plus a start while busy.
        reset_counters();
        load_poly(32'h0000_0001, 16'd0, 16'd1, 0);
        wait_cycles(3);
        pulse_start();
        run_drain(2000, 1, 1'b0, 1'b1);

        // Empty stall: one word every 10 cycles.
        reset_counters();
        load_poly(32'h0000_0001, 16'd0, 16'd1, 9);
        wait_cycles(1);
        bus.coef_ready = 1'b1;
        pulse_start();
        run_drain(5000, 0, 1'b0, 1'b0);

        // Reset mid-drain at idx 100, then a fresh drain.
        reset_counters();
        load_poly(32'h0000_0001, 16'd0, 16'd1, 0);
        wait_cycles(3);
        bus.coef_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.coef_idx == IDXW'(100)) found = 1'b1;
        end
        check("reached_idx_100", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        fifo_q.delete();
        src_q.delete();
        sb.delete();
        bus.rd_empty = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        reset_counters();
        load_poly(32'h0000_0001, 16'd0, 16'd1, 0);
        wait_cycles(3);
        pulse_start();
        run_drain(600, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
